// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream inputs share one output.
// The grant is registered and held from arbitration until the tlast beat handshakes.
module axis_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic                        pkt_done,
  output logic [15:0]                 pkt_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic              pkt_done_reg, pkt_done_next;
  logic [15:0]       pkt_count_reg, pkt_count_next;

  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              busy;
  logic              release_beat;
  logic [DATA_W-1:0] port_data [NUM_PORTS];

  assign busy = (state_reg == BUSY);

  // Ready depends only on state, grant and downstream ready, never on tvalid.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_data[gi]     = s_axis_tdata[gi*DATA_W +: DATA_W];
      assign s_axis_tready[gi] = busy && (grant_id_reg == ID_W'(gi)) && m_axis_tready;
    end
  endgenerate

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (busy) begin
      m_axis_tvalid = s_axis_tvalid[grant_id_reg];
      m_axis_tlast  = s_axis_tlast[grant_id_reg];
      if (s_axis_tvalid[grant_id_reg]) begin
        m_axis_tdata = port_data[grant_id_reg];
      end
    end
  end

  assign release_beat = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Ports above last_grant outrank the wrapped-around ports; the second loop
  // overrides the first, and descending order leaves the lowest index winning.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i] && (i <= int'(last_grant_reg))) begin
        winner  = ID_W'(i);
        any_req = 1'b1;
      end
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i] && (i > int'(last_grant_reg))) begin
        winner  = ID_W'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    pkt_done_next   = 1'b0;
    pkt_count_next  = pkt_count_reg;
    if (state_reg == IDLE) begin
      if (any_req) begin
        grant_id_next = winner;
        state_next    = BUSY;
      end
    end else begin
      if (release_beat) begin
        state_next      = IDLE;
        last_grant_next = grant_id_reg;
        pkt_done_next   = 1'b1;
        pkt_count_next  = pkt_count_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= ID_W'(NUM_PORTS - 1);
      pkt_done_reg   <= 1'b0;
      pkt_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      pkt_done_reg   <= pkt_done_next;
      pkt_count_reg  <= pkt_count_next;
    end
  end

  assign grant_valid = busy;
  assign grant_id    = grant_id_reg;
  assign pkt_done    = pkt_done_reg;
  assign pkt_count   = pkt_count_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 ports, 8-bit data).
module tb_axis_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             srst;
  logic [NP-1:0]    s_tvalid;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic             m_tvalid;
  logic [DW-1:0]    m_tdata;
  logic             m_tlast;
  logic             m_tready;
  logic             grant_valid;
  logic [IW-1:0]    grant_id;
  logic             pkt_done;
  logic [15:0]      pkt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .axis_aclk    (clk),
    .axis_areset  (srst),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .pkt_done     (pkt_done),
    .pkt_count    (pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[p]          = v;
    s_tdata[p*DW +: DW]  = d;
    s_tlast[p]           = l;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant_valid"}, grant_valid, 1'b0);
    chk({tag, ".m_tvalid"}, m_tvalid, 1'b0);
    chk({tag, ".m_tdata"}, m_tdata, 8'h00);
    chk({tag, ".m_tlast"}, m_tlast, 1'b0);
    chk({tag, ".s_tready"}, s_tready, 4'b0000);
  endtask

  task automatic chk_beat(input string tag, input int p, input logic [7:0] d, input logic l);
    logic [NP-1:0] exp_rdy;
    exp_rdy = m_tready ? (4'b0001 << p) : 4'b0000;
    chk({tag, ".grant_valid"}, grant_valid, 1'b1);
    chk({tag, ".grant_id"}, grant_id, p);
    chk({tag, ".m_tvalid"}, m_tvalid, 1'b1);
    chk({tag, ".m_tdata"}, m_tdata, d);
    chk({tag, ".m_tlast"}, m_tlast, l);
    chk({tag, ".s_tready"}, s_tready, exp_rdy);
  endtask

  initial begin
    logic [5:0] rdy_pat;
    int         beat;

    srst     = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;

    // Reset held for 5 cycles with inputs toggling
    for (int i = 0; i < 5; i++) begin
      tick();
      s_tvalid = 4'($urandom);
      s_tdata  = $urandom;
      s_tlast  = 4'($urandom);
      m_tready = 1'($urandom);
      settle();
      chk_idle($sformatf("reset%0d", i));
      chk("reset.grant_id", grant_id, 2'd0);
      chk("reset.pkt_done", pkt_done, 1'b0);
      chk("reset.pkt_count", pkt_count, 16'd0);
    end
    srst     = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    $display("reset: done");

    // Single port: port 2, four beats
    drive(2, 1'b1, 8'h10, 1'b0);
    settle();
    chk_idle("single.arb");
    tick();
    chk_beat("single.b0", 2, 8'h10, 1'b0);
    tick();
    drive(2, 1'b1, 8'h20, 1'b0);
    settle();
    chk_beat("single.b1", 2, 8'h20, 1'b0);
    tick();
    drive(2, 1'b1, 8'h30, 1'b0);
    settle();
    chk_beat("single.b2", 2, 8'h30, 1'b0);
    tick();
    drive(2, 1'b1, 8'h40, 1'b1);
    settle();
    chk_beat("single.b3", 2, 8'h40, 1'b1);
    tick();
    drive(2, 1'b0, 8'h00, 1'b0);
    settle();
    chk_idle("single.rel");
    chk("single.pkt_done", pkt_done, 1'b1);
    chk("single.pkt_count", pkt_count, 16'd1);
    chk("single.grant_id_hold", grant_id, 2'd2);
    tick();
    chk("single.pkt_done_clr", pkt_done, 1'b0);
    chk("single.pkt_count2", pkt_count, 16'd1);
    $display("single: port 2 packet of 4 beats");

    // Contention: all four ports request 2-beat packets after reset
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 8'hA0 + 8'(p), 1'b0);
    for (int p = 0; p < NP; p++) begin
      settle();
      chk_idle($sformatf("cont.idle%0d", p));
      chk("cont.pkt_count", pkt_count, 16'(p));
      if (p > 0) chk("cont.pkt_done", pkt_done, 1'b1);
      tick();
      chk_beat($sformatf("cont.p%0d.b0", p), p, 8'hA0 + 8'(p), 1'b0);
      tick();
      drive(p, 1'b1, 8'hB0 + 8'(p), 1'b1);
      settle();
      chk_beat($sformatf("cont.p%0d.b1", p), p, 8'hB0 + 8'(p), 1'b1);
      tick();
      drive(p, 1'b0, 8'h00, 1'b0);
      $display("contention: port %0d packet", p);
    end
    settle();
    chk_idle("cont.end");
    chk("cont.pkt_count4", pkt_count, 16'd4);

    // Ports 0 and 3 again: last_grant=3 so port 0 wins
    drive(0, 1'b1, 8'hC0, 1'b1);
    drive(3, 1'b1, 8'hC3, 1'b1);
    tick();
    chk_beat("rr.p0", 0, 8'hC0, 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    settle();
    chk_idle("rr.idle");
    chk("rr.pkt_count5", pkt_count, 16'd5);
    tick();
    chk_beat("rr.p3", 3, 8'hC3, 1'b1);
    tick();
    drive(3, 1'b0, 8'h00, 1'b0);
    settle();
    chk("rr.pkt_count6", pkt_count, 16'd6);
    $display("rr: port 0 then port 3");

    // Backpressure: port 1, 3 beats, ready pattern 1,0,0,1,0,1
    rdy_pat = 6'b101001;
    beat    = 0;
    drive(1, 1'b1, 8'hD1, 1'b0);
    tick();
    for (int c = 0; c < 6; c++) begin
      m_tready = rdy_pat[c];
      drive(1, 1'b1, 8'hD1 + 8'(beat), beat == 2);
      settle();
      chk_beat($sformatf("bp.c%0d", c), 1, 8'hD1 + 8'(beat), beat == 2);
      tick();
      if (rdy_pat[c]) beat++;
    end
    drive(1, 1'b0, 8'h00, 1'b0);
    m_tready = 1'b1;
    settle();
    chk_idle("bp.rel");
    chk("bp.beats", beat, 3);
    chk("bp.pkt_done", pkt_done, 1'b1);
    chk("bp.pkt_count7", pkt_count, 16'd7);
    $display("backpressure: port 1 packet of 3 beats");

    // No pre-emption: port 1 requests while port 0 is mid-packet
    drive(0, 1'b1, 8'hE0, 1'b0);
    tick();
    drive(1, 1'b1, 8'hF1, 1'b1);
    settle();
    chk_beat("npe.b0", 0, 8'hE0, 1'b0);
    tick();
    drive(0, 1'b1, 8'hE1, 1'b1);
    settle();
    chk_beat("npe.b1", 0, 8'hE1, 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    settle();
    chk_idle("npe.idle");
    chk("npe.pkt_count8", pkt_count, 16'd8);
    tick();
    chk_beat("npe.p1", 1, 8'hF1, 1'b1);
    tick();
    drive(1, 1'b0, 8'h00, 1'b0);
    settle();
    chk("npe.pkt_count9", pkt_count, 16'd9);
    $display("no-preempt: port 0 then port 1");

    // Reset mid-packet from port 3 (last_grant is 1 here)
    drive(3, 1'b1, 8'h31, 1'b0);
    tick();
    chk_beat("rst.b0", 3, 8'h31, 1'b0);
    tick();
    drive(3, 1'b1, 8'h32, 1'b0);
    settle();
    chk_beat("rst.b1", 3, 8'h32, 1'b0);
    tick();
    drive(3, 1'b1, 8'h33, 1'b0);
    srst = 1'b1;
    tick();
    chk_idle("rst.mid");
    chk("rst.grant_id", grant_id, 2'd0);
    chk("rst.pkt_count", pkt_count, 16'd0);
    chk("rst.pkt_done", pkt_done, 1'b0);
    srst = 1'b0;
    drive(3, 1'b0, 8'h00, 1'b0);
    drive(0, 1'b1, 8'h01, 1'b1);
    drive(2, 1'b1, 8'h02, 1'b1);
    tick();
    chk_beat("rst.ptr", 0, 8'h01, 1'b1);
    $display("reset-mid: pointer back to port 0");

    // Reset wins over a tlast handshake in the same cycle
    srst = 1'b1;
    tick();
    srst = 1'b0;
    settle();
    chk_idle("rstlast");
    chk("rstlast.pkt_done", pkt_done, 1'b0);
    chk("rstlast.pkt_count", pkt_count, 16'd0);
    tick();
    chk_beat("rstlast.regrant", 0, 8'h01, 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    settle();
    chk("rstlast.pkt_done1", pkt_done, 1'b1);
    chk("rstlast.pkt_count1", pkt_count, 16'd1);
    tick();
    chk_beat("rstlast.p2", 2, 8'h02, 1'b1);
    tick();
    drive(2, 1'b0, 8'h00, 1'b0);
    settle();
    chk("rstlast.pkt_count2", pkt_count, 16'd2);
    $display("reset-vs-tlast: no count on reset cycle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master output between NUM_PORTS AXI-Stream slave inputs, each driven by an 8-bit stream source of the kind used in the AXI Stream Interface blocks. A grant is held for a whole packet and released only after the beat carrying tlast completes its handshake. Data, valid and ready pass through combinationally once a grant is held; the grant is registered. The block sits between several packet sources and a single downstream AXIS sink.

## Interface
- NUM_PORTS, 4: number of slave inputs; legal range 2..16.
- DATA_W, 8: tdata width per port.
- ID_W, $clog2(NUM_PORTS): width of grant_id.
- axis_aclk  in  1  single clock; all logic on the rising edge.
- axis_areset  in  1  reset; synchronous, active-high.
- s_axis_tvalid  in  NUM_PORTS  per-port valid; bit i belongs to port i.
- s_axis_tdata  in  NUM_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W].
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tlast  out  1  output last.
- m_axis_tready  in  1  downstream ready.
- grant_valid  out  1  high while a port holds the grant.
- grant_id  out  ID_W  index of the granted port; holds the last granted index when grant_valid=0.
- pkt_done  out  1  one-cycle pulse in the cycle after a tlast handshake.
- pkt_count  out  16  count of completed packets; wraps at 0xFFFF -> 0.

## Operation
- State machine with two states, IDLE and BUSY, both registered.
- IDLE: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. If any s_axis_tvalid bit is 1, pick the winner by round-robin: the first requesting port found searching from (last_grant+1) mod NUM_PORTS upward, with wrap. Register grant_id<=winner and go to BUSY.
- BUSY, with granted port g: m_axis_tvalid=s_axis_tvalid[g], m_axis_tdata=s_axis_tdata[g], m_axis_tlast=s_axis_tlast[g], s_axis_tready[g]=m_axis_tready, and every other s_axis_tready bit is 0.
- While in BUSY, m_axis_tdata is 0 whenever m_axis_tvalid is 0.
- Release: on a beat where m_axis_tvalid & m_axis_tready & m_axis_tlast are all 1, go to IDLE, set last_grant<=g, pulse pkt_done on the next cycle, and increment pkt_count.
- Requests arriving from other ports during BUSY never pre-empt the grant; they wait for release.
- A granted port that drops tvalid mid-packet keeps the grant, with no timeout.
- Simultaneous requests are resolved by the round-robin order only. The previous winner has the lowest priority.

## Timing
- Reset values: state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first), grant_id=0, grant_valid=0, pkt_done=0, pkt_count=0, and all m_axis_* outputs and s_axis_tready are 0.
- Arbitration latency: if a request is first seen in IDLE at edge k, grant_valid=1 and the pass-through is active from edge k+1. The first beat can complete in the cycle after the grant.
- Throughput: a packet of L beats with no backpressure occupies L+1 cycles (1 arbitration cycle + L beats). Back-to-back packets, from the same port or from different ports, always have exactly one idle cycle between them.
- grant_valid falls on the edge after the tlast handshake, in the same cycle as the pkt_done pulse.
- Single-beat packet (tvalid and tlast together on the first beat): granted in cycle k+1, released at the end of k+1.
- Reset asserted mid-packet: on the next edge the block returns to IDLE, all outputs go to reset values, and the round-robin pointer resets. The partial packet is truncated downstream with no tlast; the sources must also be reset.
- Reset has priority over a tlast handshake in the same cycle, so pkt_count is not incremented.
- Ready/valid is never gated by a combinational path from tvalid to tready. s_axis_tready[g] depends only on m_axis_tready and the state.

## Test plan
- Reset: hold axis_areset for 5 cycles with all inputs toggling -> every output is 0, grant_valid=0, pkt_count=0.
- Single port: port 2 sends a 4-beat packet (0x10, 0x20, 0x30, 0x40 with tlast), m_axis_tready=1 -> grant_id=2 one cycle after tvalid, 4 beats out in order, pkt_done pulses once, pkt_count=1.
- Contention: all 4 ports request 2-beat packets at once after reset -> grant order 0,1,2,3, one idle cycle between packets, pkt_count=4. Then ports 0 and 3 request again -> port 0 wins, because last_grant=3.
- Backpressure: port 1 sends a 3-beat packet while m_axis_tready toggles 1,0,0,1,0,1 -> no beat is lost or duplicated, s_axis_tready[1] mirrors m_axis_tready, and the grant holds until the tlast handshake.
- No pre-emption: port 0 is mid-packet and port 1 asserts tvalid -> s_axis_tready[1] stays 0 until port 0's tlast beat completes, and port 1 is granted the cycle after the idle cycle.
- Reset mid-packet: assert axis_areset after beat 2 of a 4-beat packet from port 3 -> outputs are 0 on the next edge, pkt_count is unchanged (0), and after release port 0 has first priority.
